// File: rtl/msrv32_dbus_ctrl.sv
// msrv32_dbus_ctrl
// Data-bus controller for the AHB-lite data port. It takes one load/store
// request at a time from the pipeline and runs the address and data phases.
// It absorbs wait states and maps hresp ERROR or a stuck hready onto a bus
// error. It registers the read data and the load attributes for msrv32_lu,
// and it stalls the pipeline while a transfer is in flight.
module msrv32_dbus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    // pipeline request
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_write_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [1:0]        req_size_in,
    input  logic              req_unsigned_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    // AHB-lite manager
    output logic [ADDR_W-1:0] haddr_out,
    output logic [1:0]        htrans_out,
    output logic              hwrite_out,
    output logic [2:0]        hsize_out,
    output logic [DATA_W-1:0] hwdata_out,
    input  logic [DATA_W-1:0] hrdata_in,
    input  logic              hready_in,
    input  logic              hresp_in,
    // load unit side
    output logic [DATA_W-1:0] lu_data_out,
    output logic [1:0]        lu_load_size_out,
    output logic              lu_load_unsigned_out,
    output logic [1:0]        lu_iadder_1_to_0_out,
    output logic              lu_ahb_resp_out,
    // status
    output logic              done_out,
    output logic              misaligned_out,
    output logic              bus_err_out,
    output logic              stall_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // The wait counter reaches this value on the last tolerated hready=0 cycle.
    // If hready is still low on that cycle, the transfer is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // A half-word must sit on an even address and a word on a 4-byte
    // boundary. Size 11 has no legal encoding, so it is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lsb);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lsb[0];
            2'b10:   bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // The store data arrives right-aligned. Copying it onto every byte lane
    // lets the slave pick up the right lane without needing its own shifter.
    function automatic logic [DATA_W-1:0] replicate_lanes(input logic [1:0]        size,
                                                          input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    state_t     state;
    state_t     state_d;
    logic [7:0] tmo_cnt;
    logic [7:0] tmo_cnt_d;

    logic       accept;
    logic       bad_align;
    logic       start;
    logic       reject;
    logic       addr_hs;
    logic       data_hs;
    logic       tmo_hit;

    assign bad_align = is_misaligned(req_size_in, req_addr_in[1:0]);
    assign accept    = req_valid_in && (state == IDLE);
    assign start     = accept && !bad_align;
    assign reject    = accept && bad_align;
    assign addr_hs   = (state == ADDR) && hready_in;
    assign data_hs   = (state == DATA) && hready_in;
    assign tmo_hit   = (state != IDLE) && !hready_in && (tmo_cnt == TMO_LAST);

    // These two outputs follow the state register directly, so the pipeline
    // sees a stall or free slot in the same cycle the state changes.
    assign req_ready_out = (state == IDLE);
    assign stall_out     = (state == ADDR) || (state == DATA);

    // State register and wait-state counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_d;
            tmo_cnt <= tmo_cnt_d;
        end
    end

    // Next-state decode: IDLE -> ADDR -> DATA -> IDLE, with a timeout escape
    always_comb begin
        state_d   = state;
        tmo_cnt_d = tmo_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = ADDR;
                    tmo_cnt_d = 8'd0;
                end
            end
            ADDR: begin
                if (hready_in) begin
                    state_d   = DATA;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    tmo_cnt_d = 8'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt + 8'd1;
                end
            end
            DATA: begin
                if (hready_in) begin
                    state_d   = IDLE;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    tmo_cnt_d = 8'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                tmo_cnt_d = 8'd0;
            end
        endcase
    end

    // Address-phase signals: loaded on accept, held through wait states,
    // htrans dropped once the slave takes the address or the transfer times out
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            haddr_out  <= '0;
            htrans_out <= HTRANS_IDLE;
            hwrite_out <= 1'b0;
            hsize_out  <= 3'b000;
        end else begin
            if (start) begin
                haddr_out  <= req_addr_in;
                htrans_out <= HTRANS_NONSEQ;
                hwrite_out <= req_write_in;
                hsize_out  <= {1'b0, req_size_in};
            end else if (addr_hs || tmo_hit) begin
                htrans_out <= HTRANS_IDLE;
            end
        end
    end

    // Write data is captured and lane-replicated at accept. It stays stable
    // for the whole data phase, however many wait states the slave inserts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hwdata_out <= '0;
        end else if (start && req_write_in) begin
            hwdata_out <= replicate_lanes(req_size_in, req_wdata_in);
        end
    end

    // Load attributes for msrv32_lu, valid from the cycle after accept
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lu_load_size_out     <= 2'b00;
            lu_load_unsigned_out <= 1'b0;
            lu_iadder_1_to_0_out <= 2'b00;
        end else if (start) begin
            lu_load_size_out     <= req_size_in;
            lu_load_unsigned_out <= req_unsigned_in;
            lu_iadder_1_to_0_out <= req_addr_in[1:0];
        end
    end

    // Completion result: read data only on a clean load, response on every
    // completion. Both hold until the next transfer finishes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lu_data_out     <= '0;
            lu_ahb_resp_out <= 1'b0;
        end else begin
            if (data_hs) begin
                lu_ahb_resp_out <= hresp_in;
                if (!hresp_in && !hwrite_out) begin
                    lu_data_out <= hrdata_in;
                end
            end else if (tmo_hit) begin
                lu_ahb_resp_out <= 1'b1;
            end
        end
    end

    // One-cycle status pulses. Each comes from a distinct state or
    // condition, so at most one of them fires in any cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            done_out       <= 1'b0;
            misaligned_out <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            done_out       <= data_hs && !hresp_in;
            misaligned_out <= reject;
            bus_err_out    <= (data_hs && hresp_in) || tmo_hit;
        end
    end

endmodule
